// File: rtl/vending_pkg.sv
// Shared definitions for the change dispenser: coin values, the payout
// state encoding, the coin selector and helper functions.
package vending_pkg;

  localparam logic [15:0] COIN_50_VALUE = 16'd50;
  localparam logic [15:0] COIN_10_VALUE = 16'd10;
  localparam logic [15:0] COIN_5_VALUE  = 16'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_5    = 2'd1,
    COIN_10   = 2'd2,
    COIN_50   = 2'd3
  } coin_t;

  // Greedy choice: the largest coin that still fits into the value owed.
  function automatic coin_t selectCoin(input logic [15:0] value);
    if (value >= COIN_50_VALUE) begin
      return COIN_50;
    end else if (value >= COIN_10_VALUE) begin
      return COIN_10;
    end else if (value >= COIN_5_VALUE) begin
      return COIN_5;
    end
    return COIN_NONE;
  endfunction

  // Currency value of a coin type; COIN_NONE is worth nothing.
  function automatic logic [15:0] coinValue(input coin_t coin);
    case (coin)
      COIN_50: return COIN_50_VALUE;
      COIN_10: return COIN_10_VALUE;
      COIN_5:  return COIN_5_VALUE;
      default: return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Down-counter shared by the inter-coin gap and the hopper acknowledge
// timeout. Loading N makes o_expired rise after N enabled cycles, so a
// phase that loads N-1 on entry lasts exactly N cycles.
module dispense_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_enable,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // Load takes priority; otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin payout controller: pays an amount greedily in 50/10/5 coins through a
// hopper handshake, spacing coins by a gap and faulting if the hopper stalls.
// Every output is a flop loaded from the next-state view of the FSM.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] amount,
  input  logic        coin_ack,
  output logic        eject_50,
  output logic        eject_10,
  output logic        eject_5,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] remaining,
  output logic [2:0]  residue
);

  localparam int MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_nextState;
  coin_t  r_coin;
  coin_t  w_nextCoin;

  logic        r_eject50;
  logic        r_eject10;
  logic        r_eject5;
  logic        r_busy;
  logic        r_done;
  logic        r_fault;
  logic [15:0] r_remaining;
  logic [2:0]  r_residue;

  logic        w_nextEject50;
  logic        w_nextEject10;
  logic        w_nextEject5;
  logic        w_nextBusy;
  logic        w_nextDone;
  logic        w_nextFault;
  logic [15:0] w_nextRemaining;
  logic [2:0]  w_nextResidue;
  logic [15:0] w_coinValue;

  logic               w_startAccepted;
  logic               w_ackAccepted;
  logic               w_timeout;
  logic               w_timerExpired;
  logic               w_timerLoad;
  logic               w_timerEnable;
  logic [TIMER_W-1:0] w_timerLoadValue;

  assign w_startAccepted = start && ((r_state == ST_IDLE) || (r_state == ST_FAULT));
  assign w_ackAccepted   = coin_ack && (r_state == ST_EJECT);
  assign w_timeout       = (r_state == ST_EJECT) && !coin_ack && w_timerExpired;

  // The timer is armed with the timeout on entering EJECT and with the gap
  // length on an acknowledged coin; it only runs in those two states.
  assign w_timerLoad      = ((r_state == ST_SELECT) && (w_nextState == ST_EJECT)) || w_ackAccepted;
  assign w_timerLoadValue = (r_state == ST_SELECT) ? TIMEOUT_LOAD : GAP_LOAD;
  assign w_timerEnable    = (r_state == ST_EJECT) || (r_state == ST_GAP);

  dispense_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_timerLoad),
    .i_loadValue (w_timerLoadValue),
    .i_enable    (w_timerEnable),
    .o_expired   (w_timerExpired)
  );

  // State and selected-coin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_coin  <= COIN_NONE;
    end else begin
      r_state <= w_nextState;
      r_coin  <= w_nextCoin;
    end
  end

  // Next-state logic; the coin is chosen in SELECT and held through EJECT.
  always_comb begin
    w_nextState = r_state;
    w_nextCoin  = r_coin;
    case (r_state)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          w_nextState = ST_SELECT;
          w_nextCoin  = COIN_NONE;
        end
      end
      ST_SELECT: begin
        w_nextCoin  = selectCoin(r_remaining);
        w_nextState = (w_nextCoin == COIN_NONE) ? ST_FINISH : ST_EJECT;
      end
      ST_EJECT: begin
        if (coin_ack) begin
          w_nextState = ST_GAP;
        end else if (w_timerExpired) begin
          w_nextState = ST_FAULT;
        end
      end
      ST_GAP: begin
        if (w_timerExpired) begin
          w_nextState = ST_SELECT;
        end
      end
      ST_FINISH: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCoin  = COIN_NONE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  // so that each output lines up with the state it belongs to.
  always_comb begin
    w_nextEject50 = (w_nextState == ST_EJECT) && (w_nextCoin == COIN_50);
    w_nextEject10 = (w_nextState == ST_EJECT) && (w_nextCoin == COIN_10);
    w_nextEject5  = (w_nextState == ST_EJECT) && (w_nextCoin == COIN_5);
    w_nextBusy    = (w_nextState == ST_SELECT) || (w_nextState == ST_EJECT) ||
                    (w_nextState == ST_GAP);
    w_nextDone    = (w_nextState == ST_FINISH);
    w_coinValue   = coinValue(r_coin);

    w_nextFault = r_fault;
    if (w_startAccepted) begin
      w_nextFault = 1'b0;
    end else if (w_timeout) begin
      w_nextFault = 1'b1;
    end

    w_nextRemaining = r_remaining;
    if (w_startAccepted) begin
      w_nextRemaining = amount;
    end else if (w_ackAccepted) begin
      w_nextRemaining = (r_remaining >= w_coinValue) ? (r_remaining - w_coinValue) : 16'd0;
    end

    w_nextResidue = r_residue;
    if (w_startAccepted) begin
      w_nextResidue = 3'd0;
    end else if (w_nextState == ST_FINISH) begin
      w_nextResidue = r_remaining[2:0];
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eject50   <= 1'b0;
      r_eject10   <= 1'b0;
      r_eject5    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_remaining <= 16'd0;
      r_residue   <= 3'd0;
    end else begin
      r_eject50   <= w_nextEject50;
      r_eject10   <= w_nextEject10;
      r_eject5    <= w_nextEject5;
      r_busy      <= w_nextBusy;
      r_done      <= w_nextDone;
      r_fault     <= w_nextFault;
      r_remaining <= w_nextRemaining;
      r_residue   <= w_nextResidue;
    end
  end

  assign eject_50  = r_eject50;
  assign eject_10  = r_eject10;
  assign eject_5   = r_eject5;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fault     = r_fault;
  assign remaining = r_remaining;
  assign residue   = r_residue;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle cycles between coin ejections.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: cycles allowed for coin_ack before fault.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to pay out amount.
REQ-006 amount  input  16  payout value in currency units, sampled on accepted start.
REQ-007 coin_ack  input  1  hopper confirms the currently requested coin was ejected.
REQ-008 eject_50 / eject_10 / eject_5  output  1 each  coin request, at most one high, held until ack or timeout.
REQ-009 busy  output  1  payout in progress.
REQ-010 done  output  1  one-cycle pulse when payout finishes.
REQ-011 fault  output  1  hopper timeout; latched.
REQ-012 remaining  output  16  value still to be paid.
REQ-013 residue  output  3  unpayable remainder (0..4), valid from done until next start.

Function
REQ-014 The FSM SHALL have states IDLE, SELECT, EJECT, GAP, FINISH, FAULT; all outputs registered.
REQ-015 In IDLE or FAULT, start SHALL load remaining<=amount, clear fault, set busy, and go to SELECT next cycle.
REQ-016 start in SELECT/EJECT/GAP/FINISH SHALL be ignored; amount is not re-sampled.
REQ-017 SELECT SHALL choose greedily: remaining>=50 -> eject_50; else >=10 -> eject_10; else >=5 -> eject_5; else go to FINISH; a chosen coin enters EJECT.
REQ-018 Latency: start at cycle N -> first eject high at N+2.
REQ-019 In EJECT, coin_ack high SHALL subtract the coin value from remaining, drop eject next cycle, and enter GAP; the subtraction never underflows.
REQ-020 coin_ack outside EJECT SHALL be ignored.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, then return to SELECT.
REQ-022 EJECT SHALL count cycles; TIMEOUT_CYCLES without coin_ack SHALL drop eject, set fault, clear busy, and enter FAULT, leaving remaining unchanged.
REQ-023 FINISH SHALL last one cycle, pulse done, set residue<=remaining[2:0], clear busy, and return to IDLE.
REQ-024 amount=0: start at N -> done at N+2, no eject.
REQ-025 fault SHALL stay high until rst or an accepted start.

Reset
REQ-026 rst SHALL immediately force IDLE, clear all ejects, busy, done, fault, remaining=0, residue=0, and all counters.
REQ-027 rst mid-payout SHALL abandon the payout; no coin request survives reset.

Structure
REQ-028 Coin values (50, 10, 5) and the state encoding SHALL be in shared package vending_pkg.
REQ-029 The gap/timeout counter SHALL be one sub-module, dispense_timer, with load, enable, and an expired output.

Verification
REQ-030 amount=85, ack 3 cycles after each eject -> ejects 50,10,10,10,5 in order, remaining 0, done, residue 0.
REQ-031 amount=27 -> ejects 10,10,5, done, residue 2, remaining 2.
REQ-032 amount=0 -> done at N+2, no eject, residue 0.
REQ-033 amount=50, never ack -> eject_50 high for TIMEOUT_CYCLES, then fault=1, busy=0, remaining 50; a new start clears fault.
REQ-034 amount=60, rst pulsed during first GAP -> all outputs 0 at once, no further eject.
REQ-035 start with amount=100 while busy during a 15 payout -> ignored; exactly 10,5 ejected.
